// File: rtl/fetch_decode_queue_pkg.sv
// Shared widths and constants for the fetch-to-decode queue.
package fetch_decode_queue_pkg;

  localparam int unsigned ARCH_WIDTH = 32;
  localparam int unsigned FQ_DEPTH   = 4;
  localparam int unsigned FQ_ADDR_W  = $clog2(FQ_DEPTH);

  // Instruction word delivered to ID when the queue is empty.
  localparam logic [ARCH_WIDTH-1:0] BUBBLE_INSTR = 32'h0;

  // One fetched pair as presented by the IF stage.
  typedef struct packed {
    logic [ARCH_WIDTH-1:0] pc;
    logic [ARCH_WIDTH-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_decode_queue_wrap_counter.sv
// Free-wrapping pointer counter with clear; clear wins over enable.
module fetch_decode_queue_wrap_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next pointer value: clear, advance with natural wrap, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Pointer register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_decode_queue.sv
// Show-ahead FIFO between IF and ID: freezes IF when full, flushes on taken branch.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int unsigned N      = ARCH_WIDTH,
  parameter int unsigned DEPTH  = FQ_DEPTH,
  parameter int unsigned ADDR_W = FQ_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      pc_in,
  input  logic [N-1:0]      instr_in,
  input  logic              in_valid,
  output logic              freeze_out,
  input  logic              flush,
  input  logic              id_ready,
  output logic              out_valid,
  output logic [N-1:0]      pc_out,
  output logic [N-1:0]      instr_out,
  output logic [ADDR_W:0]   count
);

  logic [N-1:0]      mem_pc_q    [DEPTH];
  logic [N-1:0]      mem_instr_q [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;
  logic              full;
  logic              push;
  logic              pop;

  // Full/empty status derived only from registered occupancy.
  assign full       = (count_q == (ADDR_W+1)'(DEPTH));
  assign out_valid  = (count_q != '0);
  assign freeze_out = full;

  // Flush blocks both sides so a branch cycle neither enqueues nor retires.
  assign push = in_valid & ~full & ~flush;
  assign pop  = out_valid & id_ready & ~flush;

  fetch_decode_queue_wrap_counter #(.W(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush),
    .en_i  (push),
    .cnt_o (wr_ptr)
  );

  fetch_decode_queue_wrap_counter #(.W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush),
    .en_i  (pop),
    .cnt_o (rd_ptr)
  );

  // Occupancy update; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + (ADDR_W+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (ADDR_W+1)'(1);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage array, intentionally not reset; reads are gated by out_valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_pc_q[wr_ptr]    <= pc_in;
      mem_instr_q[wr_ptr] <= instr_in;
    end
  end

  // Head presentation: bubble when empty.
  always_comb begin
    pc_out    = '0;
    instr_out = N'(BUBBLE_INSTR);
    if (out_valid) begin
      pc_out    = mem_pc_q[rd_ptr];
      instr_out = mem_instr_q[rd_ptr];
    end
  end

  assign count = count_q;

endmodule
